vga_timing_gen: RTL and testbench

Raster timing generator for the VGA output path: divides the system clock into a pixel strobe and runs horizontal/vertical counters. It produces the pixel coordinates `x`/`y` consumed by the Tetris board renderer, along with sync, blanking and frame/line markers. Sync and blank are delayable so they stay aligned with the colour data produced downstream. Default timing is 640x480 @ 60 Hz from a 50 MHz clock.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_sync_delay.sv | 33 +++
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, sync bundle type and helpers for the VGA raster generator.
package vga_pkg;

    localparam int DEF_CLK_DIV    = 2;
    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_SYNC_DELAY = 1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    // Sync inactive (high) and blanked: what the monitor sees before the first pixel.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic int h_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: run enable in, pixel coordinates, markers and sync out.
interface vga_timing_gen_if;

    logic       i_en;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic       o_active;
    logic       o_pix_stb;
    logic       o_line_start;
    logic       o_frame_start;
    logic       o_hs;
    logic       o_vs;
    logic       o_blank_n;

    // No handshake: the consumer samples coordinates when o_pix_stb is high; i_en low freezes the raster.
    modport master (
        input  i_en,
        output o_x, o_y, o_active, o_pix_stb, o_line_start, o_frame_start,
        output o_hs, o_vs, o_blank_n
    );

    modport slave (
        output i_en,
        input  o_x, o_y, o_active, o_pix_stb, o_line_start, o_frame_start,
        input  o_hs, o_vs, o_blank_n
    );

endinterface

// File: rtl/vga_sync_delay.sv
// DEPTH-stage shift register of sync/blank bits, advancing only when enabled; DEPTH=0 passes through.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_en,
    input  vga_sync_t i_sync,
    output vga_sync_t o_sync
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{i_clk, i_rst, i_en};
        assign o_sync      = i_sync;
    end else begin : g_shift
        vga_sync_t stage_q [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= SYNC_IDLE;
            end else if (i_en) begin
                stage_q[0] <= i_sync;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign o_sync = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel-strobe divider plus horizontal/vertical raster counters with delayable sync and blank.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
    input  logic             i_clk,
    input  logic             i_rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
        H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("vga_timing_gen: totals must fit 10 bits and every segment must be non-zero");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic             line_q, line_d, frame_q, frame_d;
    logic             stb;
    logic             active;
    vga_sync_t        sync_raw, sync_dly;

    assign stb = vga.i_en && !i_rst && (div_q == DIV_LAST);

    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        line_d  = 1'b0;
        frame_d = 1'b0;
        if (vga.i_en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (stb) begin
            if (h_q == H_LAST) begin
                h_d    = '0;
                line_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d     = '0;
                    frame_d = 1'b1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    // Counters park on the last position so the very first strobe lands on (0,0).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q   <= '0;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign active           = (h_q < H_ACT) && (v_q < V_ACT);
    assign sync_raw.hs      = !((h_q >= HS_START) && (h_q < HS_END));
    assign sync_raw.vs      = !((v_q >= VS_START) && (v_q < VS_END));
    assign sync_raw.blank_n = active;

    vga_sync_delay #(.DEPTH(SYNC_DELAY)) u_sync_delay (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (stb),
        .i_sync (sync_raw),
        .o_sync (sync_dly)
    );

    assign vga.o_x           = h_q;
    assign vga.o_y           = v_q;
    assign vga.o_active      = active;
    assign vga.o_pix_stb     = stb;
    assign vga.o_line_start  = line_q;
    assign vga.o_frame_start = frame_q;
    assign vga.o_hs          = sync_dly.hs;
    assign vga.o_vs          = sync_dly.vs;
    assign vga.o_blank_n     = sync_dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small raster configurations checked every cycle against a
// pixel-index model, plus directed reset/enable/frame-count checks with literal expectations.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   done_cfg [2];

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        // cfg0: divided clock with two-stage sync delay; cfg1: undivided with no delay.
        localparam int DIV = (g == 0) ? 2 : 1;
        localparam int HA  = (g == 0) ? 8 : 5;
        localparam int HF  = (g == 0) ? 2 : 1;
        localparam int HS  = (g == 0) ? 3 : 2;
        localparam int HB  = (g == 0) ? 2 : 1;
        localparam int VA  = (g == 0) ? 6 : 4;
        localparam int VF  = 1;
        localparam int VS  = (g == 0) ? 2 : 1;
        localparam int VB  = (g == 0) ? 2 : 1;
        localparam int D   = (g == 0) ? 2 : 0;
        localparam int HT  = HA + HF + HS + HB;
        localparam int VT  = VA + VF + VS + VB;
        localparam int FRAME_CLKS   = DIV * HT * VT;
        // Hand-computed per-frame totals for each configuration.
        localparam int EXP_LINES    = (g == 0) ? 11  : 7;
        localparam int EXP_HS_LOW   = (g == 0) ? 66  : 14;
        localparam int EXP_VS_LOW   = (g == 0) ? 60  : 9;
        localparam int EXP_ACTIVE   = (g == 0) ? 96  : 20;
        localparam int EXP_STROBES  = (g == 0) ? 165 : 63;

        vga_timing_gen_if vif ();
        logic rst;
        bit   checking = 0;
        int   n = 0;
        int   e = 0;
        bit   prev_stb = 0;

        vga_timing_gen #(
            .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_DELAY(D)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .vga   (vif)
        );

        // Model state: n = strobes since reset, e = enabled-clock phase, prev_stb = strobe last cycle.
        always @(posedge clk) begin
            if (rst) begin
                n        <= 0;
                e        <= 0;
                prev_stb <= 0;
            end else begin
                prev_stb <= vif.i_en && (e == DIV - 1);
                if (vif.i_en) begin
                    e <= (e + 1) % DIV;
                    if (e == DIV - 1) n <= n + 1;
                end
            end
        end

        always @(negedge clk) begin
            int  t, lin, lx, ly, dlin, dx, dy;
            bit  ehs, evs, ebn;
            if (checking) begin
                t   = HT * VT;
                lin = (n + t - 1) % t;
                lx  = lin % HT;
                ly  = lin / HT;
                if (n >= D) begin
                    dlin = (n - D + t - 1) % t;
                    dx   = dlin % HT;
                    dy   = dlin / HT;
                    ehs  = !(dx >= HA + HF && dx < HA + HF + HS);
                    evs  = !(dy >= VA + VF && dy < VA + VF + VS);
                    ebn  = (dx < HA) && (dy < VA);
                end else begin
                    ehs = 1'b1;
                    evs = 1'b1;
                    ebn = 1'b0;
                end
                check($sformatf("cfg%0d x", g), int'(vif.o_x), lx);
                check($sformatf("cfg%0d y", g), int'(vif.o_y), ly);
                check($sformatf("cfg%0d active", g), int'(vif.o_active), int'(lx < HA && ly < VA));
                check($sformatf("cfg%0d pix_stb", g), int'(vif.o_pix_stb),
                      int'(vif.i_en && !rst && e == DIV - 1));
                check($sformatf("cfg%0d line_start", g), int'(vif.o_line_start), int'(prev_stb && lx == 0));
                check($sformatf("cfg%0d frame_start", g), int'(vif.o_frame_start), int'(prev_stb && lin == 0));
                check($sformatf("cfg%0d hs", g), int'(vif.o_hs), int'(ehs));
                check($sformatf("cfg%0d vs", g), int'(vif.o_vs), int'(evs));
                check($sformatf("cfg%0d blank_n", g), int'(vif.o_blank_n), int'(ebn));
            end
        end

        initial begin
            int c_line, c_frame, c_hs, c_vs, c_act, c_stb;
            rst      = 1'b1;
            vif.i_en = 1'b1;
            repeat (2) @(posedge clk);
            checking = 1;
            @(negedge clk);
            check($sformatf("cfg%0d reset x", g), int'(vif.o_x), HT - 1);
            check($sformatf("cfg%0d reset y", g), int'(vif.o_y), VT - 1);
            check($sformatf("cfg%0d reset hs", g), int'(vif.o_hs), 1);
            check($sformatf("cfg%0d reset vs", g), int'(vif.o_vs), 1);
            check($sformatf("cfg%0d reset blank_n", g), int'(vif.o_blank_n), 0);
            check($sformatf("cfg%0d reset pix_stb", g), int'(vif.o_pix_stb), 0);

            @(posedge clk); #1 rst = 1'b0;
            // Strobe sits in the last clock of each pixel period.
            for (int k = 0; k < DIV; k++) begin
                @(negedge clk);
                check($sformatf("cfg%0d first stb%0d", g, k), int'(vif.o_pix_stb), int'(k == DIV - 1));
                check($sformatf("cfg%0d no early frame", g), int'(vif.o_frame_start), 0);
            end
            @(negedge clk);
            check($sformatf("cfg%0d first frame_start", g), int'(vif.o_frame_start), 1);
            check($sformatf("cfg%0d first x", g), int'(vif.o_x), 0);
            check($sformatf("cfg%0d first y", g), int'(vif.o_y), 0);
            check($sformatf("cfg%0d first active", g), int'(vif.o_active), 1);

            // Advance to x=4, freeze for 20 clocks, then resume at x=5.
            repeat (4 * DIV) @(posedge clk);
            #1 vif.i_en = 1'b0;
            repeat (20) begin
                @(negedge clk);
                check($sformatf("cfg%0d frozen x", g), int'(vif.o_x), 4);
                check($sformatf("cfg%0d frozen stb", g), int'(vif.o_pix_stb), 0);
                check($sformatf("cfg%0d frozen line", g), int'(vif.o_line_start), 0);
            end
            @(posedge clk); #1 vif.i_en = 1'b1;
            repeat (DIV) @(posedge clk);
            @(negedge clk);
            check($sformatf("cfg%0d resume x", g), int'(vif.o_x), 5);

            c_line = 0; c_frame = 0; c_hs = 0; c_vs = 0; c_act = 0; c_stb = 0;
            repeat (FRAME_CLKS) begin
                @(negedge clk);
                c_line  += int'(vif.o_line_start);
                c_frame += int'(vif.o_frame_start);
                c_hs    += int'(!vif.o_hs);
                c_vs    += int'(!vif.o_vs);
                c_act   += int'(vif.o_active);
                c_stb   += int'(vif.o_pix_stb);
            end
            check($sformatf("cfg%0d lines/frame", g), c_line, EXP_LINES);
            check($sformatf("cfg%0d frames/frame", g), c_frame, 1);
            check($sformatf("cfg%0d hs low clocks", g), c_hs, EXP_HS_LOW);
            check($sformatf("cfg%0d vs low clocks", g), c_vs, EXP_VS_LOW);
            check($sformatf("cfg%0d active clocks", g), c_act, EXP_ACTIVE);
            check($sformatf("cfg%0d strobes", g), c_stb, EXP_STROBES);

            // Random enable gaps and occasional mid-frame resets against the model.
            repeat (3000) begin
                @(posedge clk);
                #1;
                vif.i_en = ($urandom_range(0, 9) != 0);
                rst      = ($urandom_range(0, 199) == 0);
            end
            @(posedge clk); #1 rst = 1'b0; vif.i_en = 1'b1;
            repeat (2 * FRAME_CLKS) @(posedge clk);
            done_cfg[g] = 1;
        end
    end

    initial begin
        int budget;
        budget = 0;
        while (!(done_cfg[0] && done_cfg[1]) && budget < 20000) begin
            @(posedge clk);
            budget++;
        end
        check("bench completion", int'(done_cfg[0] && done_cfg[1]), 1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
